// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO fed through a valid/ready
// port, drained by a serialiser that sends start, eight data bits LSB-first
// and a stop bit, each held for SYMBOL_EDGE_TIME clock cycles.
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic                          serial_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CYC_W            = $clog2(SYMBOL_EDGE_TIME);
   localparam int PTR_W            = $clog2(FIFO_DEPTH);
   localparam int CNT_W            = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [7:0]         shift;
   logic [2:0]         bit_idx;
   logic [2:0]         next_bit;
   logic [CYC_W-1:0]   cycle_cnt;
   logic               symbol_end;
   logic               push;
   logic               pop;

   // NOTE: these are continuous assigns of registered state only, so there is
   // no combinational path from data_in_valid to data_in_ready and no latch.
   assign symbol_end    = (cycle_cnt == CYC_W'(SYMBOL_EDGE_TIME - 1));
   assign data_in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
   assign push          = data_in_valid && data_in_ready;
   assign pop           = (fifo_count != '0) &&
                          ((state == IDLE) || ((state == STOP) && symbol_end));
   assign tx_busy       = (state != IDLE) || (fifo_count != '0);
   assign next_bit      = bit_idx + 3'd1;

   // Byte storage, written on every accepted push.
   // NOTE: the storage array is deliberately not reset; the pointers and count
   // define which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
   // NOTE: all sequential state uses non-blocking assignments so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Serialiser FSM with a registered, glitch-free line output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         serial_out <= 1'b1;
         shift      <= '0;
         bit_idx    <= '0;
         cycle_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               serial_out <= 1'b1;
               cycle_cnt  <= '0;
               bit_idx    <= '0;
               if (pop) begin
                  shift      <= mem[rd_ptr];
                  serial_out <= 1'b0;
                  state      <= START;
               end
            end

            START: begin
               if (symbol_end) begin
                  cycle_cnt  <= '0;
                  bit_idx    <= '0;
                  serial_out <= shift[0];
                  state      <= DATA;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end

            DATA: begin
               if (symbol_end) begin
                  cycle_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     serial_out <= 1'b1;
                     state      <= STOP;
                  end else begin
                     bit_idx    <= next_bit;
                     serial_out <= shift[next_bit];
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end

            STOP: begin
               if (symbol_end) begin
                  cycle_cnt <= '0;
                  bit_idx   <= '0;
                  if (pop) begin
                     // Back-to-back frame: start bit follows the stop bit directly.
                     shift      <= mem[rd_ptr];
                     serial_out <= 1'b0;
                     state      <= START;
                  end else begin
                     serial_out <= 1'b1;
                     state      <= IDLE;
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end

            default: begin
               serial_out <= 1'b1;
               cycle_cnt  <= '0;
               bit_idx    <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a UART line decoder checks every frame against
// a queue of bytes the stimulus knows were accepted, plus directed timing checks.
module tb_uart_tx_fifo;

   localparam int CLK_F = 1000;
   localparam int BAUD  = 100;
   localparam int S     = CLK_F / BAUD;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int S_DEF = 125_000_000 / 115_200;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    data_in = '0;
   logic          data_in_valid = 1'b0;
   logic          data_in_ready;
   logic          serial_out;
   logic          tx_busy;
   logic [CW-1:0] fifo_count;

   logic [7:0]    d_data_in = '0;
   logic          d_valid = 1'b0;
   logic          d_ready;
   logic          d_serial;
   logic          d_busy;
   logic [3:0]    d_count;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [7:0]    exp_q[$];
   int            starts[$];
   bit            mon_busy = 1'b0;

   uart_tx_fifo #(.CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .serial_out    (serial_out),
      .tx_busy       (tx_busy),
      .fifo_count    (fifo_count)
   );

   uart_tx_fifo dut_def (
      .clk           (clk),
      .rst           (rst),
      .data_in       (d_data_in),
      .data_in_valid (d_valid),
      .data_in_ready (d_ready),
      .serial_out    (d_serial),
      .tx_busy       (d_busy),
      .fifo_count    (d_count)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used to time frames.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Offer one byte for one cycle; called at a falling edge, returns at the next one.
   task automatic offer(input logic [7:0] b, output bit acc);
      data_in       = b;
      data_in_valid = 1'b1;
      acc           = data_in_ready;
      if (acc) exp_q.push_back(b);
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget, output int peak);
      int n;
      n    = 0;
      peak = int'(fifo_count);
      while ((tx_busy || mon_busy) && n < budget) begin
         @(negedge clk);
         n++;
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      check({name, "_idle_in_time"}, 32'(n < budget), 1);
   endtask

   // Line decoder: every symbol must be constant for S cycles; decoded byte
   // is compared with the oldest accepted byte.
   initial begin : monitor
      logic [9:0] val;
      bit         stable;
      bit         aborted;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && serial_out === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            stable  = 1'b1;
            aborted = 1'b0;
            val     = '0;
            for (int c = 0; c < 10 * S; c++) begin
               if (c > 0) @(negedge clk);
               if (rst !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (c % S == 0) val[c / S] = serial_out;
               else if (serial_out !== val[c / S]) stable = 1'b0;
            end
            if (!aborted) begin
               check("frame_start_bit", 32'(val[0]), 0);
               check("frame_stop_bit", 32'(val[9]), 1);
               check("frame_symbols_stable", 32'(stable), 1);
               if (exp_q.size() == 0) begin
                  check("frame_unexpected", 32'(val[8:1]), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_data", 32'(val[8:1]), 32'(e));
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bit   acc;
      int   peak, push_cyc, busy_n, full_n, n, i, bad, low, high;
      int   base;
      bit   refilled, refill_pending;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_serial_out", 32'(serial_out), 1);
      check("rst_fifo_count", 32'(fifo_count), 0);
      check("rst_tx_busy", 32'(tx_busy), 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready_after_release", 32'(data_in_ready), 1);

      // Single byte 0x55: latency, frame length, busy duration
      starts.delete();
      offer(8'h55, acc);
      check("t1_accepted", 32'(acc), 1);
      push_cyc = cyc;
      busy_n = 0;
      check("t1_count_after_push", 32'(fifo_count), 1);
      check("t1_line_idle_at_push", 32'(serial_out), 1);
      if (tx_busy) busy_n++;
      @(negedge clk);
      check("t1_count_after_pop", 32'(fifo_count), 0);
      check("t1_start_bit_begins", 32'(serial_out), 0);
      if (tx_busy) busy_n++;
      for (int k = 0; k < 500 && tx_busy; k++) begin
         @(negedge clk);
         if (tx_busy) busy_n++;
      end
      check("t1_busy_cycles", 32'(busy_n), 32'(10 * S + 1));
      check("t1_frame_start_latency", 32'(starts.size() > 0 ? starts[0] - push_cyc : -1), 1);
      check("t1_frame_consumed", 32'(exp_q.size()), 0);

      // Three bytes on consecutive cycles: contiguous frames
      repeat (3) @(negedge clk);
      starts.delete();
      offer(8'hA3, acc);
      push_cyc = cyc;
      check("t2_accept_a3", 32'(acc), 1);
      offer(8'h0F, acc);
      check("t2_accept_0f", 32'(acc), 1);
      offer(8'hFF, acc);
      check("t2_accept_ff", 32'(acc), 1);
      wait_idle("t2", 1000, peak);
      check("t2_peak_count", 32'(peak), 2);
      check("t2_frame_count", 32'(starts.size()), 3);
      if (starts.size() == 3) begin
         check("t2_first_start", 32'(starts[0] - push_cyc), 1);
         check("t2_gap_1", 32'(starts[1] - starts[0]), 32'(10 * S));
         check("t2_gap_2", 32'(starts[2] - starts[1]), 32'(10 * S));
      end

      // Hold valid for 12 distinct bytes: fill, refuse while full, refill after pop
      repeat (2) @(negedge clk);
      base = int'($urandom);
      i = 0; n = 0; full_n = 0;
      refilled = 1'b0; refill_pending = 1'b0;
      while (i < 12 && n < 2000) begin
         data_in       = 8'(base + i * 17);
         data_in_valid = 1'b1;
         if (data_in_ready) begin
            if (full_n > 0 && !refilled) begin
               check("t4_count_after_pop", 32'(fifo_count), DEPTH - 1);
               refilled       = 1'b1;
               refill_pending = 1'b1;
            end
            exp_q.push_back(data_in);
            i++;
         end else if (!refilled) begin
            if (full_n == 0) begin
               check("t3_accepted_before_full", 32'(i), 9);
               check("t3_count_full", 32'(fifo_count), DEPTH);
            end
            full_n++;
         end
         @(negedge clk);
         n++;
         if (refill_pending) begin
            check("t4_count_refilled", 32'(fifo_count), DEPTH);
            refill_pending = 1'b0;
         end
      end
      data_in_valid = 1'b0;
      check("t3_all_offered", 32'(i), 12);
      check("t4_full_cycles", 32'(full_n), 32'(10 * S - 7));
      wait_idle("t3", 3000, peak);
      check("t3_all_sent", 32'(exp_q.size()), 0);

      // Asynchronous reset in the middle of 0x81 with three bytes queued
      repeat (2) @(negedge clk);
      offer(8'h81, acc);
      for (int k = 0; k < 3; k++) offer(8'($urandom), acc);
      check("t5_count_queued", 32'(fifo_count), 3);
      repeat (20) @(negedge clk);
      check("t5_line_mid_data", 32'(serial_out), 0);
      #2 rst = 1'b0;
      #1;
      check("t5_async_serial_out", 32'(serial_out), 1);
      check("t5_async_count", 32'(fifo_count), 0);
      check("t5_async_busy", 32'(tx_busy), 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (serial_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      check("t5_idle_after_reset", 32'(bad), 0);
      check("t5_ready_after_reset", 32'(data_in_ready), 1);
      offer(8'h42, acc);
      check("t5_accept_42", 32'(acc), 1);
      wait_idle("t5", 500, peak);
      check("t5_42_sent", 32'(exp_q.size()), 0);

      // Random bursts with random gaps
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         else offer(8'($urandom), acc);
      end
      wait_idle("rand", 6000, peak);
      check("rand_all_sent", 32'(exp_q.size()), 0);

      // Default parameters: 0x00 gives start + 8 zero bits low, then the stop bit
      d_data_in = 8'h00;
      d_valid   = 1'b1;
      check("def_ready", 32'(d_ready), 1);
      @(negedge clk);
      d_valid = 1'b0;
      n = 0;
      while (d_serial && n < 100) begin
         @(negedge clk);
         n++;
      end
      low = 0;
      while (!d_serial && low < 20000) begin
         low++;
         @(negedge clk);
      end
      check("def_low_cycles", 32'(low), 32'(9 * S_DEF));
      high = 0; n = 0;
      while (d_busy && n < 5000) begin
         if (d_serial) high++;
         @(negedge clk);
         n++;
      end
      check("def_stop_cycles", 32'(high), 32'(S_DEF));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
